// File: rtl/line_pkg.sv
// Shared types and defaults for the line-overlay stage.
// The line-draw stage imports the same width constant.
package line_pkg;

    localparam int LINE_W     = 8;
    localparam int LINE_DEPTH = 4;

    typedef struct packed {
        logic [LINE_W-1:0] m;
        logic [LINE_W-1:0] c;
        logic [LINE_W-1:0] hold;
    } line_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } line_state_t;

endpackage

// File: rtl/line_req_fifo.sv
// Synchronous request FIFO with an explicit occupancy count.
// Full/empty come from the count, so pointer wrap needs no extra bit.
module line_req_fifo
    import line_pkg::*;
#(
    parameter int DW    = 3 * LINE_W,
    parameter int DEPTH = LINE_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Fullness is judged before any same-cycle pop.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/line_sched.sv
// Frame-synchronous scheduler feeding m/c/enable to the line-draw stage.
// Outputs only change on FrameIn so a line never tears mid-frame.
module line_sched
    import line_pkg::*;
#(
    parameter int W     = LINE_W,
    parameter int DEPTH = LINE_DEPTH
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         ReqValid,
    output logic                         ReqReady,
    input  logic [W-1:0]                 ReqM,
    input  logic [W-1:0]                 ReqC,
    input  logic [W-1:0]                 ReqHold,
    input  logic                         Flush,
    input  logic                         FrameIn,
    output logic [W-1:0]                 m,
    output logic [W-1:0]                 c,
    output logic                         LineEn,
    output logic                         Busy,
    output logic [$clog2(DEPTH+1)-1:0]   Level
);

    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] m;
        logic [W-1:0] c;
        logic [W-1:0] hold;
    } req_t;

    req_t        wr_req;
    req_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [LW-1:0] fifo_level;
    logic        pop;
    logic        last_frame;

    line_state_t  state_q, state_d;
    logic [W-1:0] remain_q, remain_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] c_q, c_d;

    assign wr_req = '{m: ReqM, c: ReqC, hold: ReqHold};

    line_req_fifo #(
        .DW    (3 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .push_i    (ReqValid && !Reset),
        .wr_data_i (wr_req),
        .pop_i     (pop),
        .flush_i   (Flush),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign ReqReady = !fifo_full;
    assign Level    = fifo_level;
    assign LineEn   = (state_q == ST_SHOW);
    assign Busy     = (state_q == ST_SHOW);
    assign m        = m_q;
    assign c        = c_q;

    // A flush on a boundary suppresses the pop, so nothing follows.
    assign last_frame = (state_q == ST_IDLE) || (remain_q <= W'(1));
    assign pop = FrameIn && last_frame && !fifo_empty && !Flush;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        m_d      = m_q;
        c_d      = c_q;
        if (pop) begin
            state_d  = ST_SHOW;
            m_d      = head.m;
            c_d      = head.c;
            remain_d = (head.hold == '0) ? W'(1) : head.hold;
        end else if (FrameIn && state_q == ST_SHOW) begin
            if (remain_q > W'(1)) begin
                remain_d = remain_q - W'(1);
            end else begin
                state_d  = ST_IDLE;
                remain_d = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            m_q      <= '0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            m_q      <= m_d;
            c_q      <= c_d;
        end
    end

endmodule
